uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_os_cnt.sv | 26 ++
 rtl/uart_tx.sv | 110 +++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame state encoding, default oversample ratio, idle line level.
package uart_pkg;

  localparam int   OVERSAMPLE_DEF = 16;
  localparam int   CNT_W          = 4;
  localparam logic IDLE_LEVEL     = 1'b1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    D0     = 4'd2,
    D1     = 4'd3,
    D2     = 4'd4,
    D3     = 4'd5,
    D4     = 4'd6,
    D5     = 4'd7,
    D6     = 4'd8,
    D7     = 4'd9,
    PARITY = 4'd10,
    STOP   = 4'd11
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side handshake and serial line bundle.
interface uart_tx_if;
  logic       i_clk_tx;
  logic       i_tx_start;
  logic [7:0] i_tx_data;
  logic       o_txd;
  logic       o_tx_ready;
  logic       TxDone;

  modport master (output i_clk_tx, i_tx_start, i_tx_data,
                  input  o_txd, o_tx_ready, TxDone);
  modport slave  (input  i_clk_tx, i_tx_start, i_tx_data,
                  output o_txd, o_tx_ready, TxDone);
endinterface

// File: rtl/uart_os_cnt.sv
// Oversample tick counter: counts enabled ticks 0..MAX-1 and flags the tick
// that closes a bit period. Clear has priority over counting.
module uart_os_cnt #(
  parameter int MAX = 16,
  parameter int W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  logic [W-1:0] cnt;

  assign wrap = en && !clr && (cnt == W'(MAX - 1));

  // tick counter with clear and wrap at MAX-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (en && cnt == W'(MAX-1))  cnt <= '0;
    else if (en)                      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing, LSB first, registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and STOP.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  uart_state_e state, state_nxt;
  logic [7:0]  data_q;
  logic        txd_q, txd_nxt;
  logic        done_q, done_nxt;
  logic        stop_q, stop_nxt;
  logic        wrap;
  logic        accept;
  logic [2:0]  bit_idx;

  assign accept = (state == IDLE) && bus.i_tx_start;

  uart_os_cnt #(.MAX(OVERSAMPLE), .W(CNT_W)) u_os_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (bus.i_clk_tx),
    .clr   (accept),
    .wrap  (wrap)
  );

  // next state, stop-bit index, done pulse and next line level
  always_comb begin
    state_nxt = state;
    stop_nxt  = stop_q;
    done_nxt  = 1'b0;
    txd_nxt   = IDLE_LEVEL;
    bit_idx   = 3'd0;
    case (state)
      IDLE:  if (bus.i_tx_start) state_nxt = START;
      START: if (wrap) state_nxt = D0;
      D0, D1, D2, D3, D4, D5, D6:
             if (wrap) state_nxt = uart_state_e'(state + 4'd1);
      D7: if (wrap) begin
`ifdef UART_TX_PARITY_EN
        state_nxt = PARITY;
`else
        state_nxt = STOP;
        stop_nxt  = 1'b0;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (wrap) begin
        state_nxt = STOP;
        stop_nxt  = 1'b0;
      end
`endif
      STOP: if (wrap) begin
        // last stop bit closes the frame; otherwise send another
        if (stop_q == 1'(STOP_BITS - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          stop_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // line level is decoded from the next state so o_txd is a pure flop
    case (state_nxt)
      START: txd_nxt = 1'b0;
      D0, D1, D2, D3, D4, D5, D6, D7: begin
        bit_idx = 3'(state_nxt - D0);
        txd_nxt = data_q[bit_idx];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: txd_nxt = ^data_q;
`endif
      default: txd_nxt = IDLE_LEVEL;
    endcase
  end

  // state register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      txd_q  <= IDLE_LEVEL;
      done_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      txd_q  <= txd_nxt;
      done_q <= done_nxt;
      stop_q <= stop_nxt;
    end
  end

  // byte is captured only on the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      data_q <= 8'h00;
    else if (accept) data_q <= bus.i_tx_data;
  end

  assign bus.o_txd      = txd_q;
  assign bus.o_tx_ready = (state == IDLE);
  assign bus.TxDone     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames plus hand-written corner sequences,
// expected line bits queued at stimulus time and popped at bit centres.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  int         div = 4;
  int         phase = 0;
  int         n_pass = 0;
  int         n_chk = 0;
  logic       exp_q[$];

  uart_tx_if bus ();
  uart_tx_if bus2 ();

  assign bus.i_clk_tx   = tick;
  assign bus.i_tx_start = start;
  assign bus.i_tx_data  = data;
  assign bus2.i_clk_tx   = tick;
  assign bus2.i_tx_start = start;
  assign bus2.i_tx_data  = data;

  uart_tx #(.OVERSAMPLE(16), .STOP_BITS(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  uart_tx #(.OVERSAMPLE(16), .STOP_BITS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  // tick generator: div 4 -> tick in phase 3, div 1 -> every clk, 0 -> none
  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      tick  = (div == 1) || (div == 4 && phase == 3);
    end
  end

  typedef struct {
    logic [7:0] d;
    int         dv;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par, input int nstop);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (PAR == 1) exp_q.push_back(par);
    for (int i = 0; i < nstop; i++) exp_q.push_back(1'b1);
  endtask

  // align so the first START cycle sees its first tick 3 clks later
  task automatic wait_slot();
    if (div == 4) begin
      do begin @(posedge clk); #2; end while (phase != 3);
    end else begin
      @(posedge clk); #2;
    end
  endtask

  task automatic send(input logic [7:0] d);
    wait_slot();
    start = 1'b1;
    data  = d;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // called at the start of the first START cycle; samples each bit centre
  task automatic check_frame(input int nbits, input int lead, input int bl,
                             input bit use2, input int inj);
    int   done_at = lead + bl * (nbits - 1);
    int   first_done = -1;
    int   k = 0;
    int   samp = lead / 2;
    logic txd, rdy, dn, e;
    for (int cyc = 0; cyc <= done_at; cyc++) begin
      @(negedge clk);
      txd = use2 ? bus2.o_txd : bus.o_txd;
      rdy = use2 ? bus2.o_tx_ready : bus.o_tx_ready;
      dn  = use2 ? bus2.TxDone : bus.TxDone;
      if (cyc == 0) begin
        chk("start_edge_txd", int'(txd), 0);
        chk("busy_ready", int'(rdy), 0);
      end
      if (inj >= 0 && cyc == inj) begin start = 1'b1; data = 8'h3C; end
      if (inj >= 0 && cyc == inj + 1) start = 1'b0;
      if (dn && first_done < 0) first_done = cyc;
      if (cyc == samp && k < nbits) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: bit %0d has no expected value", k);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bit%0d", k), int'(txd), int'(e));
        end
        k++;
        samp = lead + bl * (k - 1) + bl / 2;
      end
    end
    chk("txdone_cycle", first_done, done_at);
    chk("ready_at_done", int'(rdy), 1);
  endtask

  initial begin
    bit bad;
    vecs[0] = '{d: 8'hA5, dv: 4, par: 1'b0};
    vecs[1] = '{d: 8'h07, dv: 4, par: 1'b1};
    vecs[2] = '{d: 8'h00, dv: 4, par: 1'b0};
    vecs[3] = '{d: 8'hFF, dv: 4, par: 1'b0};
    vecs[4] = '{d: 8'hA5, dv: 1, par: 1'b0};
    vecs[5] = '{d: 8'h3C, dv: 1, par: 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", int'(bus.o_txd), 1);
    chk("rst_done", int'(bus.TxDone), 0);
    chk("rst_ready", int'(bus.o_tx_ready), 1);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.o_tx_ready), 1);
    chk("post_rst_txd", int'(bus.o_txd), 1);

    // table-driven frames
    foreach (vecs[i]) begin
      div = vecs[i].dv;
      repeat (3) @(posedge clk);
      push_frame(vecs[i].d, vecs[i].par, 1);
      send(vecs[i].d);
      check_frame(10 + PAR, (div == 4) ? 64 : 16, (div == 4) ? 64 : 16, 1'b0, -1);
    end

    // back-to-back with start held: 0x00 then 0xFF, data changed mid-frame
    div = 4;
    repeat (20) @(posedge clk);
    push_frame(8'h00, 1'b0, 1);
    push_frame(8'hFF, 1'b0, 1);
    wait_slot();
    start = 1'b1;
    data  = 8'h00;
    @(posedge clk); #2;
    data = 8'hFF;
    check_frame(10 + PAR, 64, 64, 1'b0, -1);
    chk("b2b_txd_in_done_cycle", int'(bus.o_txd), 1);
    @(posedge clk); #2;
    start = 1'b0;
    check_frame(10 + PAR, 63, 64, 1'b0, -1);

    // start pulse during D3 with new data is ignored
    repeat (5) @(posedge clk);
    push_frame(8'hA5, 1'b0, 1);
    send(8'hA5);
    check_frame(10 + PAR, 64, 64, 1'b0, 64 + 3 * 64 + 10);
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (!bus.o_txd || !bus.o_tx_ready) bad = 1'b1;
    end
    chk("no_second_frame", int'(bad), 0);

    // reset during D5 aborts the frame
    send(8'h5A);
    repeat (64 + 5 * 64 + 11) @(negedge clk);
    chk("pre_rst_d5_txd", int'(bus.o_txd), 0);
    #1 reset = 1'b0;
    #1;
    chk("abort_txd", int'(bus.o_txd), 1);
    chk("abort_done", int'(bus.TxDone), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    bad = 1'b0;
    repeat (800) begin
      @(negedge clk);
      if (bus.TxDone || !bus.o_txd || !bus.o_tx_ready) bad = 1'b1;
    end
    chk("abort_quiet", int'(bad), 0);

    // two stop bits on the second instance
    push_frame(8'h55, 1'b0, 2);
    send(8'h55);
    check_frame(11 + PAR, 64, 64, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
